alarm_timekeeper: RTL and testbench

ALARM_TIMEKEEPER -- requirements
Module: alarm_timekeeper

---
 rtl/alarm_timekeeper.sv | 152 +++++++++++++++
 tb/tb_alarm_timekeeper.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_timekeeper.sv
// 24-hour BCD clock with a settable alarm, ring auto-timeout and snooze.
// Time and alarm registers hold BCD digits directly so the outputs need no conversion.
module alarm_timekeeper #(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SECS  = 60
) (
  input  logic       CLK100MHZ,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       set_time,
  input  logic       set_alarm,
  input  logic       inc_hr,
  input  logic       inc_min,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       alarm_off,
  output logic [7:0] hr_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [7:0] al_hr_bcd,
  output logic [7:0] al_min_bcd,
  output logic       alarm_ring,
  output logic       snoozing
);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  localparam logic [7:0]  RING_LIMIT  = 8'(RING_SECS);
  localparam logic [11:0] SNOOZE_LOAD = 12'(SNOOZE_MIN * 60);

  state_t      state;
  logic [7:0]  ring_cnt;
  logic [11:0] snooze_cnt;

  logic       sec_wrap;
  logic       min_wrap;
  logic [7:0] min_rolled;
  logic [7:0] hr_rolled;
  logic       alarm_hit;
  logic       force_idle;

  function automatic logic [7:0] inc_mod60(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) return 8'h00;
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_mod24(input logic [7:0] v);
    if (v == 8'h23) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Values minutes/hours take when the current tick carries out of seconds.
  always_comb begin
    sec_wrap   = (sec_bcd == 8'h59);
    min_wrap   = (min_bcd == 8'h59);
    min_rolled = sec_wrap ? inc_mod60(min_bcd) : min_bcd;
    hr_rolled  = (sec_wrap && min_wrap) ? inc_mod24(hr_bcd) : hr_bcd;
    alarm_hit  = tick_1hz && !set_time && !set_alarm && alarm_en && sec_wrap &&
                 (min_rolled == al_min_bcd) && (hr_rolled == al_hr_bcd);
    force_idle = !alarm_en || set_time;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      hr_bcd  <= 8'h00;
      min_bcd <= 8'h00;
      sec_bcd <= 8'h00;
    end else if (set_time) begin
      sec_bcd <= 8'h00;
      if (inc_min) min_bcd <= inc_mod60(min_bcd);
      if (inc_hr)  hr_bcd  <= inc_mod24(hr_bcd);
    end else if (tick_1hz) begin
      sec_bcd <= inc_mod60(sec_bcd);
      min_bcd <= min_rolled;
      hr_bcd  <= hr_rolled;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      al_hr_bcd  <= 8'h07;
      al_min_bcd <= 8'h00;
    end else if (set_alarm && !set_time) begin
      if (inc_min) al_min_bcd <= inc_mod60(al_min_bcd);
      if (inc_hr)  al_hr_bcd  <= inc_mod24(al_hr_bcd);
    end
  end

  // Outputs are written alongside every state change so they track the state register.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state      <= IDLE;
      alarm_ring <= 1'b0;
      snoozing   <= 1'b0;
      ring_cnt   <= 8'd0;
      snooze_cnt <= 12'd0;
    end else begin
      case (state)
        IDLE: begin
          if (alarm_hit) begin
            state      <= RING;
            alarm_ring <= 1'b1;
            ring_cnt   <= 8'd0;
          end
        end
        RING: begin
          if (force_idle || alarm_off) begin
            state      <= IDLE;
            alarm_ring <= 1'b0;
          end else if (snooze) begin
            state      <= SNOOZE;
            alarm_ring <= 1'b0;
            snoozing   <= 1'b1;
            snooze_cnt <= SNOOZE_LOAD;
          end else if (tick_1hz) begin
            ring_cnt <= ring_cnt + 8'd1;
            if (ring_cnt + 8'd1 == RING_LIMIT) begin
              state      <= IDLE;
              alarm_ring <= 1'b0;
            end
          end
        end
        SNOOZE: begin
          if (force_idle || alarm_off) begin
            state    <= IDLE;
            snoozing <= 1'b0;
          end else if (tick_1hz) begin
            if (snooze_cnt == 12'd1) begin
              state      <= RING;
              snoozing   <= 1'b0;
              alarm_ring <= 1'b1;
              ring_cnt   <= 8'd0;
              snooze_cnt <= 12'd0;
            end else begin
              snooze_cnt <= snooze_cnt - 12'd1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          alarm_ring <= 1'b0;
          snoozing   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_timekeeper.sv
// Bench for alarm_timekeeper: seconds-of-day reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic near the alarm.
module tb_alarm_timekeeper;

  localparam int SNOOZE_MIN_TB = 2;
  localparam int RING_SECS_TB  = 20;

  logic       CLK100MHZ = 1'b0;
  logic       rst, tick_1hz, set_time, set_alarm, inc_hr, inc_min;
  logic       alarm_en, snooze, alarm_off;
  logic [7:0] hr_bcd, min_bcd, sec_bcd, al_hr_bcd, al_min_bcd;
  logic       alarm_ring, snoozing;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: time as seconds of day, alarm as minute of day, 0/1/2 = idle/ring/snooze.
  int m_t = 0, m_al = 0, m_st = 0, m_ring_el = 0, m_snz_left = 0;
  int m_h, m_m, m_ah, m_am;
  bit m_hit;
  bit model_valid = 1'b0;

  alarm_timekeeper #(
    .SNOOZE_MIN(SNOOZE_MIN_TB),
    .RING_SECS (RING_SECS_TB)
  ) dut (
    .CLK100MHZ (CLK100MHZ),
    .rst       (rst),
    .tick_1hz  (tick_1hz),
    .set_time  (set_time),
    .set_alarm (set_alarm),
    .inc_hr    (inc_hr),
    .inc_min   (inc_min),
    .alarm_en  (alarm_en),
    .snooze    (snooze),
    .alarm_off (alarm_off),
    .hr_bcd    (hr_bcd),
    .min_bcd   (min_bcd),
    .sec_bcd   (sec_bcd),
    .al_hr_bcd (al_hr_bcd),
    .al_min_bcd(al_min_bcd),
    .alarm_ring(alarm_ring),
    .snoozing  (snoozing)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
  endtask

  initial forever begin
    @(posedge CLK100MHZ);
    if (rst) begin
      m_t = 0; m_al = 7 * 60; m_st = 0; m_ring_el = 0; m_snz_left = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      m_h = m_t / 3600;
      m_m = (m_t / 60) % 60;
      if (set_time) begin
        if (inc_min) m_m = (m_m + 1) % 60;
        if (inc_hr)  m_h = (m_h + 1) % 24;
        m_t = m_h * 3600 + m_m * 60;
      end else if (tick_1hz) begin
        m_t = (m_t + 1) % 86400;
      end
      if (set_alarm && !set_time) begin
        m_ah = m_al / 60;
        m_am = m_al % 60;
        if (inc_min) m_am = (m_am + 1) % 60;
        if (inc_hr)  m_ah = (m_ah + 1) % 24;
        m_al = m_ah * 60 + m_am;
      end
      m_hit = tick_1hz && !set_time && !set_alarm && alarm_en &&
              (m_t % 60 == 0) && (m_t / 60 == m_al);
      if (m_st == 0) begin
        if (m_hit) begin m_st = 1; m_ring_el = 0; end
      end else if (!alarm_en || set_time || alarm_off) begin
        m_st = 0;
      end else if (m_st == 1) begin
        if (snooze) begin
          m_st = 2; m_snz_left = SNOOZE_MIN_TB * 60;
        end else if (tick_1hz) begin
          m_ring_el++;
          if (m_ring_el >= RING_SECS_TB) m_st = 0;
        end
      end else if (tick_1hz) begin
        m_snz_left--;
        if (m_snz_left == 0) begin m_st = 1; m_ring_el = 0; end
      end
    end
  end

  initial forever begin
    @(negedge CLK100MHZ);
    if (model_valid)
      checkOutput("cycle", {hr_bcd, min_bcd, sec_bcd, al_hr_bcd, al_min_bcd, alarm_ring, snoozing},
                  {bcd(m_t / 3600), bcd((m_t / 60) % 60), bcd(m_t % 60), bcd(m_al / 60),
                   bcd(m_al % 60), m_st == 1, m_st == 2});
  end

  task automatic applyStimulus(input bit rs, tk, st, sa, ih, im, en, sz, off);
    rst = rs; tick_1hz = tk; set_time = st; set_alarm = sa; inc_hr = ih; inc_min = im;
    alarm_en = en; snooze = sz; alarm_off = off;
    @(posedge CLK100MHZ);
    @(negedge CLK100MHZ);
    rst = 1'b0; tick_1hz = 1'b0; inc_hr = 1'b0; inc_min = 1'b0; snooze = 1'b0; alarm_off = 1'b0;
  endtask

  task automatic ticks(input int n, input bit en);
    repeat (n) begin
      applyStimulus(0, 1, 0, 0, 0, 0, en, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, en, 0, 0);
    end
  endtask

  task automatic setClock(input int h, input int m, input bit en);
    int guard;
    guard = 0;
    while ((m_t / 3600) != h && guard < 30) begin applyStimulus(0, 0, 1, 0, 1, 0, en, 0, 0); guard++; end
    guard = 0;
    while (((m_t / 60) % 60) != m && guard < 70) begin applyStimulus(0, 0, 1, 0, 0, 1, en, 0, 0); guard++; end
    checkOutput("set_clock", {hr_bcd, min_bcd, sec_bcd}, {bcd(h), bcd(m), 8'h00});
  endtask

  task automatic setAlarm(input int h, input int m);
    int guard;
    guard = 0;
    while ((m_al / 60) != h && guard < 30) begin applyStimulus(0, 0, 0, 1, 1, 0, 1, 0, 0); guard++; end
    guard = 0;
    while ((m_al % 60) != m && guard < 70) begin applyStimulus(0, 0, 0, 1, 0, 1, 1, 0, 0); guard++; end
    checkOutput("set_alarm", {al_hr_bcd, al_min_bcd}, {bcd(h), bcd(m)});
  endtask

  task automatic ringAt0700();
    setClock(6, 59, 1);
    ticks(60, 1);
    checkOutput("ring_at_0700", {hr_bcd, min_bcd, alarm_ring, snoozing}, {16'h0700, 2'b10});
  endtask

  initial begin
    int al_h, al_m, pre;
    bit rs, tk, st, sa, ih, im, en, sz, off;
    rst = 1'b0; tick_1hz = 1'b0; set_time = 1'b0; set_alarm = 1'b0; inc_hr = 1'b0;
    inc_min = 1'b0; alarm_en = 1'b0; snooze = 1'b0; alarm_off = 1'b0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_time",  {hr_bcd, min_bcd, sec_bcd}, 24'h000000);
    checkOutput("reset_alarm", {al_hr_bcd, al_min_bcd}, 16'h0700);
    checkOutput("reset_flags", {alarm_ring, snoozing}, 2'b00);

    repeat (61) applyStimulus(0, 0, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("set_min_wrap", {hr_bcd, min_bcd, sec_bcd}, 24'h000100);
    repeat (25) applyStimulus(0, 0, 1, 0, 1, 0, 0, 0, 0);
    checkOutput("set_hr_wrap", {hr_bcd, min_bcd, sec_bcd}, 24'h010100);
    applyStimulus(0, 0, 1, 0, 1, 1, 0, 0, 0);
    checkOutput("set_both_inc", {hr_bcd, min_bcd, sec_bcd}, 24'h020200);

    setClock(23, 59, 0);
    ticks(59, 0);
    checkOutput("pre_rollover", {hr_bcd, min_bcd, sec_bcd}, 24'h235959);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rollover", {hr_bcd, min_bcd, sec_bcd}, 24'h000000);

    setClock(6, 59, 1);
    ticks(58, 1);
    checkOutput("pre_alarm", {hr_bcd, min_bcd, sec_bcd, alarm_ring}, {24'h065958, 1'b0});
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("alarm_hit", {hr_bcd, min_bcd, sec_bcd, alarm_ring}, {24'h070000, 1'b1});
    ticks(RING_SECS_TB - 1, 1);
    checkOutput("ring_hold", {alarm_ring, snoozing}, 2'b10);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("ring_timeout", {alarm_ring, snoozing}, 2'b00);

    ringAt0700();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0);
    checkOutput("snooze_enter", {alarm_ring, snoozing}, 2'b01);
    ticks(SNOOZE_MIN_TB * 60 - 1, 1);
    checkOutput("snooze_hold", {alarm_ring, snoozing}, 2'b01);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("snooze_expire", {alarm_ring, snoozing}, 2'b10);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1);
    checkOutput("alarm_off", {alarm_ring, snoozing}, 2'b00);

    ringAt0700();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1);
    checkOutput("snooze_and_off", {alarm_ring, snoozing}, 2'b00);
    ringAt0700();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0);
    ticks(3, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("en_drop_snooze", {alarm_ring, snoozing}, 2'b00);

    ringAt0700();
    applyStimulus(1, 1, 0, 0, 0, 0, 1, 1, 0);
    checkOutput("reset_mid_ring", {hr_bcd, min_bcd, sec_bcd, al_hr_bcd, al_min_bcd, alarm_ring, snoozing},
                {24'h000000, 16'h0700, 2'b00});

    for (int round = 0; round < 6; round++) begin
      al_h = int'($urandom_range(0, 23));
      al_m = int'($urandom_range(0, 59));
      setAlarm(al_h, al_m);
      pre = (al_h * 60 + al_m + 1439) % 1440;
      setClock(pre / 60, pre % 60, 1);
      for (int c = 0; c < 400; c++) begin
        rs  = ($urandom % 600) == 0;
        tk  = ($urandom % 2) == 0;
        st  = ($urandom % 200) == 0;
        sa  = ($urandom % 100) == 0;
        ih  = ($urandom % 12) == 0;
        im  = ($urandom % 12) == 0;
        en  = ($urandom % 30) != 0;
        sz  = ($urandom % 25) == 0;
        off = ($urandom % 60) == 0;
        applyStimulus(rs, tk, st, sa, ih, im, en, sz, off);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
